data_cache: RTL and testbench

- Responder end of the CPU data-memory interface (readC2/writeC2/address2/writeCacheData -> cacheData2/cacheHit2/writeToData).
- Direct-mapped, write-through, no-write-allocate cache between the pipelined CPU MEM stage and word-wide main memory.
- Read hits are answered combinationally in the request cycle; misses stall the CPU while the line is filled word by word.
- Writes are forwarded to memory, with writeToData held high until memory accepts the write.

---
 rtl/data_cache.sv | 159 +++++++++++++++
 tb/tb_data_cache.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache between the CPU MEM stage
// and a word-wide main memory; read misses stall the CPU while the line fills word by word.
module data_cache #(
  parameter int WORD_SIZE  = 16,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 4
) (
  input  logic                 Clk,
  input  logic                 Reset_N,
  input  logic                 readC,
  input  logic                 writeC,
  input  logic [WORD_SIZE-1:0] address,
  input  logic [WORD_SIZE-1:0] writeData,
  output logic [WORD_SIZE-1:0] cacheData,
  output logic                 cacheHit,
  output logic                 writeToData,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_ready,
  output logic [15:0]          hit_count,
  output logic [15:0]          miss_count
);

  localparam int OFF_BITS  = $clog2(LINE_WORDS);
  localparam int IDX_BITS  = $clog2(NUM_LINES);
  localparam int TAG_BITS  = WORD_SIZE - OFF_BITS - IDX_BITS;
  localparam int LINE_BITS = WORD_SIZE - OFF_BITS;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE} state_t;

  state_t                 state_q;
  logic [NUM_LINES-1:0]   valid_q;
  logic [TAG_BITS-1:0]    tag_q  [NUM_LINES];
  logic [WORD_SIZE-1:0]   data_q [NUM_LINES][LINE_WORDS];
  logic [OFF_BITS-1:0]    cnt_q;
  logic [LINE_BITS-1:0]   line_q;
  logic                   mem_read_q;
  logic                   mem_write_q;
  logic [WORD_SIZE-1:0]   mem_addr_q;
  logic [WORD_SIZE-1:0]   mem_wdata_q;
  logic                   wtd_q;
  logic [15:0]            hit_cnt_q;
  logic [15:0]            miss_cnt_q;

  logic [OFF_BITS-1:0]    off;
  logic [IDX_BITS-1:0]    idx;
  logic [TAG_BITS-1:0]    tag;
  logic [IDX_BITS-1:0]    fill_idx;
  logic [TAG_BITS-1:0]    fill_tag;
  logic                   hit;
  logic                   rd_req;
  logic                   last_word;

  assign off       = address[OFF_BITS-1:0];
  assign idx       = address[OFF_BITS +: IDX_BITS];
  assign tag       = address[WORD_SIZE-1 -: TAG_BITS];
  assign fill_idx  = line_q[IDX_BITS-1:0];
  assign fill_tag  = line_q[LINE_BITS-1 -: TAG_BITS];
  assign hit       = valid_q[idx] && (tag_q[idx] == tag);
  assign rd_req    = readC && !writeC;
  assign last_word = (cnt_q == OFF_BITS'(LINE_WORDS - 1));

  always_comb begin
    cacheHit  = 1'b1;
    cacheData = '0;
    case (state_q)
      S_IDLE: begin
        cacheHit = !(rd_req && !hit);
        if (rd_req && hit) cacheData = data_q[idx][off];
      end
      S_FILL:  cacheHit = 1'b0;
      default: cacheHit = 1'b1;
    endcase
  end

  assign writeToData = wtd_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign hit_count   = hit_cnt_q;
  assign miss_count  = miss_cnt_q;

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q     <= S_IDLE;
      valid_q     <= '0;
      cnt_q       <= '0;
      line_q      <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wtd_q       <= 1'b0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (writeC) begin
            mem_addr_q  <= address;
            mem_wdata_q <= writeData;
            mem_write_q <= 1'b1;
            wtd_q       <= 1'b1;
            state_q     <= S_WRITE;
          end else if (readC) begin
            if (hit) begin
              hit_cnt_q <= hit_cnt_q + 16'd1;
            end else begin
              // Line is invalidated up front so an aborted fill can never hit.
              miss_cnt_q     <= miss_cnt_q + 16'd1;
              valid_q[idx]   <= 1'b0;
              line_q         <= address[WORD_SIZE-1:OFF_BITS];
              cnt_q          <= '0;
              mem_read_q     <= 1'b1;
              mem_addr_q     <= {address[WORD_SIZE-1:OFF_BITS], {OFF_BITS{1'b0}}};
              state_q        <= S_FILL;
            end
          end
        end
        S_FILL: begin
          if (mem_ready) begin
            if (last_word) begin
              valid_q[fill_idx] <= 1'b1;
              mem_read_q        <= 1'b0;
              cnt_q             <= '0;
              state_q           <= S_IDLE;
            end else begin
              cnt_q      <= cnt_q + 1'b1;
              mem_addr_q <= {line_q, OFF_BITS'(cnt_q + 1'b1)};
            end
          end
        end
        S_WRITE: begin
          if (mem_ready) begin
            mem_write_q <= 1'b0;
            wtd_q       <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Data and tag storage carry no reset; the valid bits alone gate their use.
  always_ff @(posedge Clk) begin
    if (state_q == S_IDLE && writeC && hit)
      data_q[idx][off] <= writeData;
    if (state_q == S_FILL && mem_ready) begin
      data_q[fill_idx][cnt_q] <= mem_rdata;
      if (last_word) tag_q[fill_idx] <= fill_tag;
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Directed plus randomized bench for data_cache, checked against a line-level
// reference model and an independent flat memory image.
module tb_data_cache;

  logic        Clk = 1'b0;
  logic        Reset_N;
  logic        readC, writeC;
  logic [15:0] address, writeData;
  logic [15:0] cacheData;
  logic        cacheHit, writeToData;
  logic        mem_read, mem_write;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;
  logic [15:0] hit_count, miss_count;

  data_cache dut (
    .Clk(Clk), .Reset_N(Reset_N), .readC(readC), .writeC(writeC),
    .address(address), .writeData(writeData), .cacheData(cacheData),
    .cacheHit(cacheHit), .writeToData(writeToData), .mem_read(mem_read),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .hit_count(hit_count),
    .miss_count(miss_count)
  );

  always #5 Clk = ~Clk;

  bit [15:0] dmem    [0:65535];
  bit [15:0] ref_mem [0:65535];
  bit [3:0]  mv;
  logic [11:0] mt [4];
  int hit_exp, miss_exp;
  int n_pass, n_total, n_fail;
  int fixed_lat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory responder: answers each strobe after a short latency with a one-cycle mem_ready.
  initial begin
    int lat;
    bit busy;
    busy = 0; lat = 0; mem_ready = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge Clk);
      if (Reset_N !== 1'b1) begin
        busy = 0; mem_ready = 1'b0;
      end else if (mem_ready) begin
        mem_ready = 1'b0; busy = 0;
      end else if (!busy) begin
        if (mem_read || mem_write) begin
          busy = 1;
          lat = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 3));
        end
      end else begin
        lat--;
        if (lat == 0) begin
          mem_ready = 1'b1;
          if (mem_write) dmem[mem_addr] = mem_wdata;
          else           mem_rdata = dmem[mem_addr];
        end
      end
    end
  end

  task automatic check_counters(input string tag);
    chk({tag, "_hits"}, hit_count, hit_exp);
    chk({tag, "_misses"}, miss_count, miss_exp);
  endtask

  task automatic rd(input logic [15:0] a);
    bit h;
    int k, cyc;
    logic [15:0] base;
    h = mv[a[3:2]] && (mt[a[3:2]] == a[15:4]);
    @(negedge Clk);
    readC = 1'b1; writeC = 1'b0; address = a; writeData = 16'($urandom);
    #4;
    if (h) begin
      chk("rd_hit_flag", cacheHit, 1);
      chk("rd_hit_data", cacheData, ref_mem[a]);
      chk("rd_hit_noread", mem_read, 0);
      hit_exp++;
    end else begin
      chk("rd_miss_flag", cacheHit, 0);
      base = {a[15:2], 2'b00};
      k = 0; cyc = 0;
      while (cacheHit !== 1'b1 && cyc < 200) begin
        if (mem_ready === 1'b1) begin
          chk("fill_addr", mem_addr, base + 16'(k));
          k++;
        end
        @(negedge Clk); #4;
        cyc++;
      end
      chk("fill_timeout", cyc < 200, 1);
      chk("fill_words", k, 4);
      chk("fill_data", cacheData, ref_mem[a]);
      chk("fill_read_off", mem_read, 0);
      miss_exp++; hit_exp++;
      mv[a[3:2]] = 1'b1; mt[a[3:2]] = a[15:4];
    end
    @(negedge Clk);
    readC = 1'b0;
    #4;
    check_counters("rd");
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    int cyc;
    @(negedge Clk);
    writeC = 1'b1; readC = 1'($urandom_range(0, 1)); address = a; writeData = d;
    #4;
    chk("wr_req_cachehit", cacheHit, 1);
    @(negedge Clk);
    writeC = 1'b0; readC = 1'b0; address = 16'($urandom); writeData = 16'($urandom);
    #4;
    chk("wr_mem_write", mem_write, 1);
    chk("wr_mem_addr", mem_addr, a);
    chk("wr_mem_wdata", mem_wdata, d);
    chk("wr_wtd", writeToData, 1);
    chk("wr_cachehit", cacheHit, 1);
    cyc = 0;
    while (writeToData === 1'b1 && cyc < 50) begin
      @(negedge Clk); #4;
      cyc++;
    end
    chk("wr_timeout", cyc < 50, 1);
    chk("wr_strobe_off", mem_write, 0);
    ref_mem[a] = d;
    check_counters("wr");
  endtask

  initial begin
    int k, cyc;
    n_pass = 0; n_total = 0; n_fail = 0; fixed_lat = 2;
    hit_exp = 0; miss_exp = 0; mv = '0;
    for (int i = 0; i < 4; i++) mt[i] = '0;
    for (int i = 0; i < 256; i++) begin
      dmem[i] = 16'($urandom);
      ref_mem[i] = dmem[i];
    end
    for (int i = 0; i < 4; i++) begin
      dmem[16 + i] = 16'hA0 + 16'(i);
      ref_mem[16 + i] = dmem[16 + i];
    end
    Reset_N = 1'b0; readC = 1'b0; writeC = 1'b0; address = '0; writeData = '0;
    #12;
    chk("rst_cachehit", cacheHit, 1);
    chk("rst_cachedata", cacheData, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_wtd", writeToData, 0);
    check_counters("rst");
    @(negedge Clk);
    Reset_N = 1'b1;

    // cold read, hit, write hit, write miss, conflict eviction
    rd(16'h0012);
    chk("t1_data_const", cacheData === 16'h0000 ? 16'hA2 : 16'h0, 16'hA2);
    rd(16'h0011);
    wr(16'h0013, 16'h5555);
    rd(16'h0013);
    wr(16'h0040, 16'h1234);
    rd(16'h0040);
    rd(16'h0010);
    rd(16'h0050);
    rd(16'h0010);
    rd(16'h0052);

    // reset in the middle of a line fill
    @(negedge Clk);
    readC = 1'b1; writeC = 1'b0; address = 16'h0012;
    #4;
    k = 0; cyc = 0;
    while (k < 2 && cyc < 100) begin
      if (mem_ready === 1'b1) k++;
      @(negedge Clk); #4;
      cyc++;
    end
    chk("rstfill_timeout", cyc < 100, 1);
    chk("rstfill_pre_read", mem_read, 1);
    @(negedge Clk);
    Reset_N = 1'b0; readC = 1'b0;
    #1;
    chk("rstfill_mem_read", mem_read, 0);
    chk("rstfill_mem_addr", mem_addr, 0);
    chk("rstfill_cachehit", cacheHit, 1);
    chk("rstfill_cachedata", cacheData, 0);
    hit_exp = 0; miss_exp = 0; mv = '0;
    check_counters("rstfill");
    @(negedge Clk);
    Reset_N = 1'b1;
    rd(16'h0012);

    // randomized mix of reads and writes
    fixed_lat = 0;
    for (int i = 0; i < 60; i++) begin
      logic [15:0] a;
      a = 16'($urandom_range(0, 95));
      if ($urandom_range(0, 3) == 0) wr(a, 16'($urandom));
      else                           rd(a);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
